// File: rtl/hlsm_drv_pkg.sv
// rtl/hlsm_drv_pkg.sv - shared types, constants and helpers for the HLSM stimulus driver
// Contents:
//   state_t       FSM states IDLE, LOAD, START, WAIT, NEXT, FINISH (3-bit)
//   LFSR_TAPS     Galois tap mask for the right-shifting 16-bit LFSR
//   DEFAULT_SEED  reset value of the LFSR
//   IDX_*         operand slot numbers in load order a..h, num
//   lfsr_step     one LFSR step
//   sat_inc16     16-bit increment that sticks at all-ones
package hlsm_drv_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    START  = 3'd2,
    WAIT   = 3'd3,
    NEXT   = 3'd4,
    FINISH = 3'd5
  } state_t;

  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  localparam int NUM_OPERANDS = 9;

  localparam logic [3:0] IDX_A   = 4'd0;
  localparam logic [3:0] IDX_B   = 4'd1;
  localparam logic [3:0] IDX_C   = 4'd2;
  localparam logic [3:0] IDX_D   = 4'd3;
  localparam logic [3:0] IDX_E   = 4'd4;
  localparam logic [3:0] IDX_F   = 4'd5;
  localparam logic [3:0] IDX_G   = 4'd6;
  localparam logic [3:0] IDX_H   = 4'd7;
  localparam logic [3:0] IDX_NUM = 4'd8;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// rtl/lfsr16.sv - 16-bit Galois LFSR with look-ahead output
// Ports:
//   Clk    in   system clock, rising edge
//   Rst    in   synchronous active-high reset, reloads seed
//   step   in   advance the register one position this cycle
//   seed   in   16-bit reset value (nonzero)
//   value  out  the value the register takes after one step from its
//               current contents, so a consumer that loads on the same
//               edge as the step captures the freshly stepped value
module lfsr16
  import hlsm_drv_pkg::*;
(
  input  logic        Clk,
  input  logic        Rst,
  input  logic        step,
  input  logic [15:0] seed,
  output logic [15:0] value
);

  logic [15:0] lfsr_q;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      lfsr_q <= seed;
    end else if (step) begin
      lfsr_q <= lfsr_step(lfsr_q);
    end
  end

  assign value = lfsr_step(lfsr_q);

endmodule

// File: rtl/hlsm_stim_driver.sv
// rtl/hlsm_stim_driver.sv - Start/Done initiator that feeds LFSR operands to an HLSM
// Ports:
//   Clk, Rst           clock and synchronous active-high reset
//   Enable             leaves IDLE when high (sampled in IDLE only)
//   Start              one-cycle request pulse to the HLSM
//   Done, avg          HLSM completion and its result
//   a..h, num          operands, reloaded from the LFSR before each Start
//   Result             avg captured on Done
//   ResultValid        one-cycle pulse when Result updates
//   LastLatency        Start-to-Done cycles of the last transaction
//   TransCount         completed transactions (saturating)
//   Timeout            sticky: Done missed within TIMEOUT cycles
//   Busy, Finished     activity / terminal-state levels
module hlsm_stim_driver
  import hlsm_drv_pkg::*;
#(
  parameter int          DATAWIDTH = 8,
  parameter int          NUM_TRANS = 16,
  parameter int          TIMEOUT   = 64,
  parameter logic [15:0] SEED      = DEFAULT_SEED
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Enable,
  output logic                 Start,
  input  logic                 Done,
  output logic [DATAWIDTH-1:0] a,
  output logic [DATAWIDTH-1:0] b,
  output logic [DATAWIDTH-1:0] c,
  output logic [DATAWIDTH-1:0] d,
  output logic [DATAWIDTH-1:0] e,
  output logic [DATAWIDTH-1:0] f,
  output logic [DATAWIDTH-1:0] g,
  output logic [DATAWIDTH-1:0] h,
  output logic [DATAWIDTH-1:0] num,
  input  logic [DATAWIDTH-1:0] avg,
  output logic [DATAWIDTH-1:0] Result,
  output logic                 ResultValid,
  output logic [15:0]          LastLatency,
  output logic [15:0]          TransCount,
  output logic                 Timeout,
  output logic                 Busy,
  output logic                 Finished
);

  localparam logic [15:0] TRANS_TARGET = 16'(NUM_TRANS);
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

  state_t                 state;
  logic [3:0]             index;
  logic [15:0]            cycle_cnt;
  logic [DATAWIDTH-1:0]   operand [NUM_OPERANDS];
  logic [15:0]            lfsr_value;
  logic                   lfsr_unused;

  lfsr16 u_lfsr (
    .Clk   (Clk),
    .Rst   (Rst),
    .step  (state == LOAD),
    .seed  (SEED),
    .value (lfsr_value)
  );

  // Only the low DATAWIDTH bits become operands.
  assign lfsr_unused = ^lfsr_value;

  assign a   = operand[IDX_A];
  assign b   = operand[IDX_B];
  assign c   = operand[IDX_C];
  assign d   = operand[IDX_D];
  assign e   = operand[IDX_E];
  assign f   = operand[IDX_F];
  assign g   = operand[IDX_G];
  assign h   = operand[IDX_H];
  assign num = operand[IDX_NUM];

  // Outputs are registered alongside the state: each one is written on the
  // edge that enters the state it describes, so Start is high exactly
  // during START and Busy/Finished track the state with no decode glitch.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state       <= IDLE;
      index       <= IDX_A;
      cycle_cnt   <= '0;
      Start       <= 1'b0;
      Result      <= '0;
      ResultValid <= 1'b0;
      LastLatency <= '0;
      TransCount  <= '0;
      Timeout     <= 1'b0;
      Busy        <= 1'b0;
      Finished    <= 1'b0;
      for (int i = 0; i < NUM_OPERANDS; i++) begin
        operand[i] <= '0;
      end
    end else begin
      Start       <= 1'b0;
      ResultValid <= 1'b0;
      case (state)
        IDLE: begin
          if (Enable) begin
            state <= LOAD;
            index <= IDX_A;
            Busy  <= 1'b1;
          end
        end
        LOAD: begin
          operand[index] <= lfsr_value[DATAWIDTH-1:0];
          if (index == IDX_NUM) begin
            state <= START;
            Start <= 1'b1;
          end else begin
            index <= index + 4'd1;
          end
        end
        START: begin
          // Done is deliberately not looked at here: a Done overlapping
          // Start still belongs to the previous request.
          cycle_cnt <= '0;
          state     <= WAIT;
        end
        WAIT: begin
          cycle_cnt <= sat_inc16(cycle_cnt);
          if (Done) begin
            Result      <= avg;
            ResultValid <= 1'b1;
            LastLatency <= sat_inc16(cycle_cnt);
            TransCount  <= sat_inc16(TransCount);
            state       <= NEXT;
          end else if (cycle_cnt == TIMEOUT_LAST) begin
            Timeout  <= 1'b1;
            Busy     <= 1'b0;
            Finished <= 1'b1;
            state    <= FINISH;
          end
        end
        NEXT: begin
          if (TransCount == TRANS_TARGET) begin
            Busy     <= 1'b0;
            Finished <= 1'b1;
            state    <= FINISH;
          end else begin
            index <= IDX_A;
            state <= LOAD;
          end
        end
        FINISH: begin
          state <= FINISH;
        end
        default: begin
          Busy     <= 1'b0;
          Finished <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hlsm_stim_driver.sv
// tb/tb_hlsm_stim_driver.sv - self-checking bench for hlsm_stim_driver
module tb_hlsm_stim_driver;

  localparam int DW = 8;
  localparam int NT = 3;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          done = 1'b0;
  logic [DW-1:0] avg = '0;

  logic          Start, ResultValid, Timeout, Busy, Finished;
  logic [DW-1:0] a, b, c, d, e, f, g, h, num, Result;
  logic [15:0]   LastLatency, TransCount;

  hlsm_stim_driver #(.DATAWIDTH(DW), .NUM_TRANS(NT), .TIMEOUT(TO), .SEED(16'hACE1)) dut (
    .Clk(clk), .Rst(rst), .Enable(enable), .Start(Start), .Done(done),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h), .num(num),
    .avg(avg), .Result(Result), .ResultValid(ResultValid),
    .LastLatency(LastLatency), .TransCount(TransCount), .Timeout(Timeout),
    .Busy(Busy), .Finished(Finished)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_on = 0;
  int n_start = 0;

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, rc);
    end
  endtask

  // Cycle number relative to the last reset: cycle 0 is the first cycle after reset.
  int rc = 0;
  always @(posedge clk) begin
    if (rst) rc = 0;
    else rc = rc + 1;
  end

  // Responder: raises Done for one cycle 'lat' cycles after it sees Start
  // (lat = 0 means never); force_done holds Done high regardless.
  int lat = 9;
  int start_rc = -1000;
  int resp_n = 0;
  bit force_done = 0;
  always @(negedge clk) begin
    #1;
    if (Start) start_rc = rc;
    if (lat > 0 && rc == start_rc + lat) begin
      avg = 8'h2A + 8'(resp_n);
      resp_n++;
      done = 1'b1;
    end else begin
      done = force_done;
    end
  end

  // Behavioural model. m_t is the position inside a transaction:
  // 0 = not running, 1..9 = loading operand m_t-1, 10 = Start cycle,
  // 11.. = waiting (Start-to-now distance is m_t-10), -1 = after a Done.
  int          m_t = 0;
  bit          m_fin = 0;
  int unsigned m_lfsr = 16'hACE1;
  int          m_tc = 0;
  int          m_lat = 0;
  logic [7:0]  e_op [9];
  logic [7:0]  e_result = '0;
  logic        e_rv = 0, e_to = 0, e_start = 0, e_busy = 0, e_fin = 0;

  function automatic int unsigned m_step(input int unsigned x);
    if (x % 2 == 1) return (x / 2) ^ 32'hB400;
    return x / 2;
  endfunction

  always @(posedge clk) begin
    e_rv = 1'b0;
    if (rst) begin
      m_t = 0; m_fin = 0; m_lfsr = 16'hACE1; m_tc = 0; m_lat = 0;
      e_result = '0; e_to = 0;
      for (int i = 0; i < 9; i++) e_op[i] = '0;
    end else if (m_fin) begin
      m_t = 0;
    end else if (m_t == 0) begin
      if (enable) m_t = 1;
    end else if (m_t >= 1 && m_t <= 9) begin
      m_lfsr = m_step(m_lfsr);
      e_op[m_t-1] = 8'(m_lfsr % 256);
      m_t++;
    end else if (m_t == 10) begin
      m_t = 11;
    end else if (m_t == -1) begin
      if (m_tc == NT) begin m_fin = 1; m_t = 0; end
      else m_t = 1;
    end else begin
      if (done) begin
        m_lat = (m_t - 10 > 65535) ? 65535 : m_t - 10;
        e_result = avg;
        e_rv = 1'b1;
        if (m_tc < 65535) m_tc++;
        m_t = -1;
      end else if (m_t - 10 == TO) begin
        e_to = 1; m_fin = 1; m_t = 0;
      end else begin
        m_t++;
      end
    end
    e_start = (m_t == 10);
    e_busy  = (!m_fin && m_t != 0);
    e_fin   = m_fin;
  end

  always @(posedge clk) begin
    #1;
    if (chk_on) begin
      check("Start", 16'(Start), 16'(e_start));
      check("Busy", 16'(Busy), 16'(e_busy));
      check("Finished", 16'(Finished), 16'(e_fin));
      check("Timeout", 16'(Timeout), 16'(e_to));
      check("ResultValid", 16'(ResultValid), 16'(e_rv));
      check("Result", 16'(Result), 16'(e_result));
      check("LastLatency", LastLatency, 16'(m_lat));
      check("TransCount", TransCount, 16'(m_tc));
      check("a", 16'(a), 16'(e_op[0]));
      check("b", 16'(b), 16'(e_op[1]));
      check("c", 16'(c), 16'(e_op[2]));
      check("d", 16'(d), 16'(e_op[3]));
      check("e", 16'(e), 16'(e_op[4]));
      check("f", 16'(f), 16'(e_op[5]));
      check("g", 16'(g), 16'(e_op[6]));
      check("h", 16'(h), 16'(e_op[7]));
      check("num", 16'(num), 16'(e_op[8]));
    end
    if (Start === 1'b1) n_start++;
  end

  // Holds reset for two edges, then releases it with Enable high; on return
  // the bench is in cycle 0 at a falling edge.
  task automatic do_reset(input int latency);
    rst = 1'b1; enable = 1'b0; force_done = 0; lat = latency;
    start_rc = -1000; resp_n = 0;
    repeat (2) @(negedge clk);
    chk_on = 1;
    n_start = 0;
    rst = 1'b0; enable = 1'b1;
  endtask

  task automatic goto_rc(input int n);
    for (int k = 0; k < 500 && rc != n; k++) @(negedge clk);
    if (rc != n) begin
      n_cmp++; n_err++;
      $display("FAIL goto_rc: stuck at cycle %0d waiting for %0d", rc, n);
    end
  endtask

  initial begin
    @(negedge clk);

    // Normal run: three transactions, 9-cycle responder
    do_reset(9);
    goto_rc(1);  check("busy_c1", 16'(Busy), 16'd1);
    goto_rc(9);  check("start_c9", 16'(Start), 16'd0);
    goto_rc(10); check("start_c10", 16'(Start), 16'd1);
    check("a_lit", 16'(a), 16'h70);
    check("b_lit", 16'(b), 16'h38);
    check("c_lit", 16'(c), 16'h9C);
    goto_rc(11); check("start_c11", 16'(Start), 16'd0);
    goto_rc(20); check("rv_c20", 16'(ResultValid), 16'd1);
    check("result_c20", 16'(Result), 16'h2A);
    check("latency_c20", LastLatency, 16'd9);
    check("count_c20", TransCount, 16'd1);
    goto_rc(21); check("rv_c21", 16'(ResultValid), 16'd0);
    goto_rc(61); check("finished_c61", 16'(Finished), 16'd1);
    check("busy_c61", 16'(Busy), 16'd0);
    check("count_c61", TransCount, 16'd3);
    check("result_c61", 16'(Result), 16'h2C);
    check("start_pulses_3", 16'(n_start), 16'd3);
    force_done = 1;
    repeat (6) @(negedge clk);
    force_done = 0;
    goto_rc(75); check("count_after_fin", TransCount, 16'd3);
    check("pulses_after_fin", 16'(n_start), 16'd3);

    // Done held high through IDLE, LOAD and START
    do_reset(9);
    force_done = 1;
    goto_rc(11);
    force_done = 0;
    check("count_forced", TransCount, 16'd0);
    check("rv_forced", 16'(ResultValid), 16'd0);
    goto_rc(20); check("count_wait_done", TransCount, 16'd1);
    check("latency_forced", LastLatency, 16'd9);

    // Reset in the middle of the second WAIT
    goto_rc(33);
    check("busy_c33", 16'(Busy), 16'd1);
    rst = 1'b1; start_rc = -1000; resp_n = 0;
    @(negedge clk);
    check("rst_start", 16'(Start), 16'd0);
    check("rst_busy", 16'(Busy), 16'd0);
    check("rst_count", TransCount, 16'd0);
    check("rst_result", 16'(Result), 16'd0);
    check("rst_latency", LastLatency, 16'd0);
    check("rst_a", 16'(a), 16'd0);
    check("rst_num", 16'(num), 16'd0);
    rst = 1'b0;
    goto_rc(10); check("a_after_rst", 16'(a), 16'h70);
    check("start_after_rst", 16'(Start), 16'd1);

    // Responder that never answers
    do_reset(0);
    goto_rc(74); check("to_c74", 16'(Timeout), 16'd0);
    check("busy_c74", 16'(Busy), 16'd1);
    goto_rc(75); check("to_c75", 16'(Timeout), 16'd1);
    check("fin_c75", 16'(Finished), 16'd1);
    check("count_to", TransCount, 16'd0);
    goto_rc(95); check("to_sticky", 16'(Timeout), 16'd1);
    check("start_once", 16'(n_start), 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
